// File: rtl/data_memory.sv
// Byte-addressed data memory with a fixed-latency request/response port.
// Little-endian byte/half/word loads and stores; addresses wrap at DEPTH_BYTES.
module data_memory #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] cnt_nxt;

  logic          write_q;
  logic [1:0]    size_q;
  logic          signed_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;

  logic [7:0] bytes [DEPTH_BYTES];

  logic          idle;
  logic          hs;
  logic          enter_resp;
  logic          a_write;
  logic [1:0]    a_size;
  logic          a_signed;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    be;
  logic [AW-1:0] idx [4];
  logic [31:0]   raw;
  logic [31:0]   load_data;
  logic          unused_addr;

  assign idle    = (state_q == IDLE);
  assign hs      = req_valid && idle;
  assign cnt_nxt = {1'b0, cnt_q} + 5'd1;

  // With no wait states the access completes on the handshake edge,
  // so the live request is used while idle and the capture otherwise.
  assign a_write  = idle ? req_write  : write_q;
  assign a_size   = idle ? req_size   : size_q;
  assign a_signed = idle ? req_signed : signed_q;
  assign a_addr   = idle ? req_addr[AW-1:0] : addr_q;
  assign a_wdata  = idle ? req_wdata  : wdata_q;

  assign enter_resp  = (state_d == RESP) && (state_q != RESP);
  assign unused_addr = ^req_addr[31:AW];

  // Next-state, wait counter and ready
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        cnt_d     = 4'd0;
        if (req_valid) begin
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_nxt == 5'(WAIT_STATES)) begin
          state_d = RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_nxt[3:0];
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Byte enables from access size; illegal size touches nothing
  always_comb begin
    be = 4'b0000;
    case (a_size)
      2'b00:   be = 4'b0001;
      2'b01:   be = 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Wrapped byte indices and little-endian gather of enabled bytes
  always_comb begin
    raw = 32'h0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = a_addr + AW'(k);
      if (be[k]) begin
        raw[8*k +: 8] = bytes[idx[k]];
      end
    end
  end

  // Zero/sign extension of load data; stores return zero
  always_comb begin
    load_data = 32'h0;
    case (a_size)
      2'b00: load_data = {{24{a_signed & raw[7]}}, raw[7:0]};
      2'b01: load_data = {{16{a_signed & raw[15]}}, raw[15:0]};
      2'b10: load_data = raw;
      default: load_data = 32'h0;
    endcase
    if (a_write) begin
      load_data = 32'h0;
    end
  end

  // State, counter and response registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= enter_resp;
      resp_rdata_q <= enter_resp ? load_data : 32'h0;
      resp_err_q   <= enter_resp && (a_size == 2'b11);
    end
  end

  // Capture the request so later input changes cannot disturb it
  always_ff @(posedge clk) begin
    if (hs) begin
      write_q  <= req_write;
      size_q   <= req_size;
      signed_q <= req_signed;
      addr_q   <= req_addr[AW-1:0];
      wdata_q  <= req_wdata;
    end
  end

  // Store commit on the RESP-entry edge, suppressed by reset
  always_ff @(posedge clk) begin
    if (reset_n && enter_resp && a_write) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          bytes[idx[k]] <= a_wdata[8*k +: 8];
        end
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: two instances (2 and 0 wait states) checked
// against a byte-array reference model with directed and random accesses.
module tb_data_memory;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        v0, v1;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rdy0, rv0, err0;
  logic [31:0] rd0;
  logic        rdy1, rv1, err1;
  logic [31:0] rd1;

  int ncmp  = 0;
  int nfail = 0;

  logic [7:0] mem [2][1024];

  always #5 clk = ~clk;

  data_memory #(.DEPTH_BYTES(1024), .WAIT_STATES(2)) u0 (
    .clk(clk), .reset_n(rst0),
    .req_valid(v0), .req_ready(rdy0),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0)
  );

  data_memory #(.DEPTH_BYTES(1024), .WAIT_STATES(0)) u1 (
    .clk(clk), .reset_n(rst1),
    .req_valid(v1), .req_ready(rdy1),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(err1)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int widx(input logic [31:0] addr, input int k);
    return int'((addr + 32'(k)) % 32'd1024);
  endfunction

  function automatic logic [31:0] mload(input int s, input logic wr,
      input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    logic [31:0] v;
    int n;
    v = 32'h0;
    n = nbytes(size);
    if (wr) return 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mem[s][widx(addr, k)];
    if (sgn && n > 0 && n < 4 && v[8*n-1]) begin
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic mstore(input int s, input logic [1:0] size,
      input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 0; k < nbytes(size); k++) begin
      mem[s][widx(addr, k)] = wdata[8*k +: 8];
    end
  endtask

  task automatic set_valid(input int s, input logic v);
    if (s == 0) v0 = v;
    else v1 = v;
  endtask

  // Caller is #1 after an edge with the DUT idle.
  task automatic access(input int s, input logic wr, input logic [1:0] size,
      input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
      output logic [31:0] rdata, output logic err);
    int w;
    logic [31:0] exp;
    w = (s == 0) ? 2 : 0;
    exp = mload(s, wr, size, sgn, addr);
    rdata = 32'h0;
    err = 1'b0;
    chk("ready_before", 32'(s ? rdy1 : rdy0), 32'd1);
    req_write = wr;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wdata;
    set_valid(s, 1'b1);
    @(posedge clk);
    #1;
    if (wr) mstore(s, size, addr, wdata);
    for (int c = 1; c <= w + 1; c++) begin
      chk("ready_busy", 32'(s ? rdy1 : rdy0), 32'd0);
      chk("resp_valid", 32'(s ? rv1 : rv0), 32'(c == w + 1));
      if (c == w + 1) begin
        rdata = s ? rd1 : rd0;
        err = s ? err1 : err0;
        chk("rdata", rdata, exp);
        chk("err", 32'(err), 32'(size == 2'b11));
      end else begin
        chk("rdata_idle", s ? rd1 : rd0, 32'h0);
        chk("err_idle", 32'(s ? err1 : err0), 32'd0);
      end
      req_write = 1'($urandom);
      req_size = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      set_valid(s, 1'($urandom));
      @(posedge clk);
      #1;
    end
    set_valid(s, 1'b0);
    chk("ready_after", 32'(s ? rdy1 : rdy0), 32'd1);
    chk("valid_after", 32'(s ? rv1 : rv0), 32'd0);
    chk("rdata_after", s ? rd1 : rd0, 32'h0);
  endtask

  task automatic chk_mem(input int s, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk(s ? "mem1" : "mem0",
          32'(s ? u1.bytes[i] : u0.bytes[i]), 32'(mem[s][i]));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    logic [31:0] a;
    int s;

    rst0 = 1'b0;
    rst1 = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(rv0), 32'd0);
    chk("rst_rdata", rd0, 32'h0);
    chk("rst_err", 32'(err0), 32'd0);
    chk("rst_valid1", 32'(rv1), 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_ready", 32'(rdy0), 32'd1);
    chk("rst_ready1", 32'(rdy1), 32'd1);

    for (int i = 0; i < 1024; i += 4) begin
      access(0, 1'b1, 2'b10, 1'b0, 32'(i), $urandom, rd, er);
      access(1, 1'b1, 2'b10, 1'b0, 32'(i), $urandom, rd, er);
    end
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b1, 2'b10, 1'b0, 32'd0, 32'h0100_0000, rd, er);
      access(d, 1'b1, 2'b10, 1'b0, 32'd4, 32'h0403_0201, rd, er);
    end

    access(0, 1'b0, 2'b10, 1'b0, 32'd0, 32'h0, rd, er);
    chk("w_ld0", rd, 32'h0100_0000);
    access(0, 1'b1, 2'b10, 1'b0, 32'd8, 32'hF0C0_D0E0, rd, er);
    access(0, 1'b0, 2'b10, 1'b0, 32'd6, 32'h0, rd, er);
    chk("w_ld6", rd, 32'hD0E0_0403);
    access(0, 1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, er);
    chk("w_ld8", rd, 32'hF0C0_D0E0);
    access(0, 1'b0, 2'b00, 1'b1, 32'd11, 32'h0, rd, er);
    chk("b_ld11s", rd, 32'hFFFF_FFF0);
    access(0, 1'b0, 2'b00, 1'b0, 32'd11, 32'h0, rd, er);
    chk("b_ld11u", rd, 32'h0000_00F0);
    access(0, 1'b0, 2'b01, 1'b1, 32'd9, 32'h0, rd, er);
    chk("h_ld9s", rd, 32'hFFFF_C0D0);
    access(0, 1'b1, 2'b01, 1'b0, 32'd1023, 32'h0000_ABCD, rd, er);
    chk("wrap_b1023", 32'(u0.bytes[1023]), 32'h0000_00CD);
    chk("wrap_b0", 32'(u0.bytes[0]), 32'h0000_00AB);
    access(0, 1'b0, 2'b10, 1'b0, 32'd1023, 32'h0, rd, er);
    chk("wrap_ld", rd, 32'h0000_ABCD);
    access(0, 1'b1, 2'b11, 1'b0, 32'd4, 32'hFFFF_FFFF, rd, er);
    chk("ill_err", 32'(er), 32'd1);
    chk("ill_rdata", rd, 32'h0);
    access(0, 1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, er);
    chk("ill_ld4", rd, 32'h0403_0201);

    // reset during WAIT
    req_write = 1'b1;
    req_size = 2'b10;
    req_addr = 32'd16;
    req_wdata = 32'h1234_5678;
    v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    chk("abortw_valid", 32'(rv0), 32'd0);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("abortw_ready", 32'(rdy0), 32'd1);
    chk("abortw_valid2", 32'(rv0), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abortw_valid3", 32'(rv0), 32'd0);
    chk_mem(0, 16, 19);

    // reset on the RESP-entry edge
    v0 = 1'b1;
    @(posedge clk);
    #1;
    v0 = 1'b0;
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    @(posedge clk);
    #1;
    chk("abortr_valid", 32'(rv0), 32'd0);
    chk("abortr_rdata", rd0, 32'h0);
    rst0 = 1'b1;
    @(posedge clk);
    #1;
    chk("abortr_ready", 32'(rdy0), 32'd1);
    chk("abortr_valid2", 32'(rv0), 32'd0);
    chk_mem(0, 16, 19);

    // zero wait states: reset on the handshake edge, then a real store
    req_write = 1'b1;
    req_size = 2'b10;
    req_addr = 32'd16;
    req_wdata = 32'h1234_5678;
    v1 = 1'b1;
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    chk("abort0_valid", 32'(rv1), 32'd0);
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    chk("abort0_ready", 32'(rdy1), 32'd1);
    chk("abort0_valid2", 32'(rv1), 32'd0);
    chk_mem(1, 16, 19);
    access(1, 1'b1, 2'b10, 1'b0, 32'd16, 32'h1234_5678, rd, er);
    access(1, 1'b0, 2'b10, 1'b0, 32'd16, 32'h0, rd, er);
    chk("ws0_ld16", rd, 32'h1234_5678);

    for (int n = 0; n < 400; n++) begin
      s = n % 2;
      a = $urandom;
      if ($urandom_range(3) == 0) begin
        a = {a[31:10], 10'd1020 + 10'($urandom_range(3))};
      end
      access(s, 1'($urandom), 2'($urandom), 1'($urandom), a,
             $urandom, rd, er);
    end
    chk_mem(0, 0, 1023);
    chk_mem(1, 0, 1023);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
